// File: rtl/retire_trace_buffer_pkg.sv
// Shared definitions for the retire trace buffer: FSM states and the layout
// of a stored trace entry {pc, data, rd}.
package retire_trace_buffer_pkg;

  typedef enum logic [1:0] {
    TR_IDLE = 2'd0,
    TR_PRE  = 2'd1,
    TR_POST = 2'd2,
    TR_DONE = 2'd3
  } tr_state_e;

  localparam int TR_RD_W      = 5;
  localparam int TR_RD_LSB    = 0;
  localparam int TR_DATA_LSB  = TR_RD_LSB + TR_RD_W;
  localparam int TR_XLEN_DEF  = 32;
  localparam int TR_PC_LSB    = TR_DATA_LSB + TR_XLEN_DEF;

  // PC field offset for an arbitrary XLEN (data sits between rd and pc).
  function automatic int tr_pc_lsb(input int xlen);
    return TR_DATA_LSB + xlen;
  endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Capture, control and readout signals of the retire trace buffer.
// The master side is the CPU tap / debug host, the slave side is the buffer.
interface retire_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * XLEN + 5;

  logic            wb_valid;
  logic [XLEN-1:0] wb_pc;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd;
  logic            arm;
  logic [XLEN-1:0] trig_pc;
  logic [AW:0]     post_len;
  logic [CYC_W-1:0] cyc_limit;
  logic [AW-1:0]   rd_idx;
  logic [EW-1:0]   rd_entry;
  logic [AW:0]     count;
  logic [AW-1:0]   trig_idx;
  logic            triggered;
  logic            done;
  logic            timeout;

  modport master (
    output wb_valid, wb_pc, wb_data, wb_rd, arm, trig_pc, post_len, cyc_limit, rd_idx,
    input  rd_entry, count, trig_idx, triggered, done, timeout
  );

  modport slave (
    input  wb_valid, wb_pc, wb_data, wb_rd, arm, trig_pc, post_len, cyc_limit, rd_idx,
    output rd_entry, count, trig_idx, triggered, done, timeout
  );

endinterface

// File: rtl/retire_trace_buffer_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module retire_trace_buffer_trace_ram #(
  parameter int AW = 4,
  parameter int W  = 69
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  input  logic          rhit,
  output logic [W-1:0]  rdata
);
  localparam int N = 1 << AW;

  logic [W-1:0] mem_q [N];
  logic [W-1:0] rdata_q;

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register: out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= {W{1'b0}};
    end else if (rhit) begin
      rdata_q <= mem_q[raddr];
    end else begin
      rdata_q <= {W{1'b0}};
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/retire_trace_buffer.sv
// Records retired MEM/WB instructions into a ring buffer with trigger,
// post-trigger, stop-when-full and timeout control; readable at any time.
module retire_trace_buffer
  import retire_trace_buffer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int MODE  = 0,
  parameter int CYC_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  retire_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * XLEN + 5;
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);

  tr_state_e        state_q, state_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      post_cnt_q, post_cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [AW-1:0]    trig_wptr_q, trig_wptr_d;
  logic [AW-1:0]    trig_idx_q, trig_idx_d;
  logic             triggered_q, triggered_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic [CYC_W-1:0] cyc_inc_s;
  logic             trig_hit_s;
  logic             post_last_s;
  logic             full_stop_s;
  logic             time_up_s;
  logic             we_s;
  logic [EW-1:0]    wdata_s;
  logic [AW-1:0]    oldest_s;
  logic [AW-1:0]    oldest_d_s;
  logic [AW-1:0]    raddr_s;
  logic             rhit_s;
  logic [EW-1:0]    rd_entry_s;

  assign cyc_inc_s   = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
  assign trig_hit_s  = (state_q == TR_PRE) && bus.wb_valid && (bus.wb_pc == bus.trig_pc);
  assign post_last_s = (state_q == TR_POST) && bus.wb_valid && (post_cnt_q == (AW+1)'(1));
  assign full_stop_s = (MODE == 1) && bus.wb_valid && (count_q == DEPTH_M1);
  assign time_up_s   = (bus.cyc_limit != {CYC_W{1'b0}}) && (cyc_inc_s == bus.cyc_limit);

  // Once the buffer has wrapped, the oldest entry sits at the write pointer.
  assign oldest_s = (count_q == DEPTH_C) ? wptr_q : {AW{1'b0}};
  assign raddr_s  = oldest_s + bus.rd_idx;
  assign rhit_s   = ({1'b0, bus.rd_idx} < count_q);

  // Pack the retiring instruction into the entry layout.
  always_comb begin
    wdata_s = {EW{1'b0}};
    wdata_s[TR_RD_LSB +: TR_RD_W]     = bus.wb_rd;
    wdata_s[TR_DATA_LSB +: XLEN]      = bus.wb_data;
    wdata_s[tr_pc_lsb(XLEN) +: XLEN]  = bus.wb_pc;
  end

  // Next-state logic for the capture FSM, pointers, counters and flags.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    post_cnt_d  = post_cnt_q;
    cyc_d       = cyc_q;
    trig_wptr_d = trig_wptr_q;
    triggered_d = triggered_q;
    timeout_d   = timeout_q;
    we_s        = 1'b0;
    if (bus.arm) begin
      // arm takes priority; a same-cycle retire is dropped
      state_d     = TR_PRE;
      wptr_d      = {AW{1'b0}};
      count_d     = {(AW+1){1'b0}};
      post_cnt_d  = {(AW+1){1'b0}};
      cyc_d       = {CYC_W{1'b0}};
      trig_wptr_d = {AW{1'b0}};
      triggered_d = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      case (state_q)
        TR_PRE, TR_POST: begin
          cyc_d = cyc_inc_s;
          if (bus.wb_valid) begin
            we_s    = 1'b1;
            wptr_d  = wptr_q + AW'(1);
            count_d = (count_q == DEPTH_C) ? count_q : count_q + (AW+1)'(1);
          end else begin
            we_s = 1'b0;
          end
          if (trig_hit_s) begin
            triggered_d = 1'b1;
            trig_wptr_d = wptr_q;
            post_cnt_d  = bus.post_len;
          end else if ((state_q == TR_POST) && bus.wb_valid) begin
            post_cnt_d = post_cnt_q - (AW+1)'(1);
          end else begin
            post_cnt_d = post_cnt_q;
          end
          if (time_up_s || full_stop_s || post_last_s ||
              (trig_hit_s && (bus.post_len == {(AW+1){1'b0}}))) begin
            state_d = TR_DONE;
          end else if (trig_hit_s) begin
            state_d = TR_POST;
          end else begin
            state_d = state_q;
          end
          timeout_d = time_up_s;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    done_d = (state_d == TR_DONE);
  end

  // Trigger position relative to the oldest entry after this cycle's update.
  always_comb begin
    oldest_d_s = (count_d == DEPTH_C) ? wptr_d : {AW{1'b0}};
    trig_idx_d = trig_wptr_d - oldest_d_s;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TR_IDLE;
      wptr_q      <= {AW{1'b0}};
      count_q     <= {(AW+1){1'b0}};
      post_cnt_q  <= {(AW+1){1'b0}};
      cyc_q       <= {CYC_W{1'b0}};
      trig_wptr_q <= {AW{1'b0}};
      trig_idx_q  <= {AW{1'b0}};
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      post_cnt_q  <= post_cnt_d;
      cyc_q       <= cyc_d;
      trig_wptr_q <= trig_wptr_d;
      trig_idx_q  <= trig_idx_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  retire_trace_buffer_trace_ram #(
    .AW (AW),
    .W  (EW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we_s),
    .waddr (wptr_q),
    .wdata (wdata_s),
    .raddr (raddr_s),
    .rhit  (rhit_s),
    .rdata (rd_entry_s)
  );

  assign bus.rd_entry  = rd_entry_s;
  assign bus.count     = count_q;
  assign bus.trig_idx  = trig_idx_q;
  assign bus.triggered = triggered_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: a wrap-mode and a stop-full
// instance see the same stimulus; each expectation names the instance it checks.
module tb_retire_trace_buffer;
  localparam int AW = 4;
  localparam int EW = 69;

  typedef struct {
    int              dut;
    logic            ce;
    logic [EW-1:0]   ent;
    logic            cs;
    logic [AW:0]     cnt;
    logic [AW-1:0]   tidx;
    logic            trg;
    logic            dn;
    logic            to;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        arm;
  logic [31:0] trig_pc;
  logic [4:0]  post_len;
  logic [31:0] cyc_limit;
  logic [3:0]  rd_idx0;
  logic [3:0]  rd_idx1;

  exp_t  exp_q[$];
  string name_q[$];
  int    req_n;
  int    vld_n;
  int    n_vec;
  int    n_err;
  exp_t  e;
  string nm;

  retire_trace_buffer_if #(.XLEN(32), .DEPTH(16), .CYC_W(32)) if0 ();
  retire_trace_buffer_if #(.XLEN(32), .DEPTH(16), .CYC_W(32)) if1 ();

  assign if0.wb_valid  = wb_valid;   assign if1.wb_valid  = wb_valid;
  assign if0.wb_pc     = wb_pc;      assign if1.wb_pc     = wb_pc;
  assign if0.wb_data   = wb_data;    assign if1.wb_data   = wb_data;
  assign if0.wb_rd     = wb_rd;      assign if1.wb_rd     = wb_rd;
  assign if0.arm       = arm;        assign if1.arm       = arm;
  assign if0.trig_pc   = trig_pc;    assign if1.trig_pc   = trig_pc;
  assign if0.post_len  = post_len;   assign if1.post_len  = post_len;
  assign if0.cyc_limit = cyc_limit;  assign if1.cyc_limit = cyc_limit;
  assign if0.rd_idx    = rd_idx0;    assign if1.rd_idx    = rd_idx1;

  retire_trace_buffer #(.XLEN(32), .DEPTH(16), .MODE(0), .CYC_W(32)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  retire_trace_buffer #(.XLEN(32), .DEPTH(16), .MODE(1), .CYC_W(32)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk_entry(input logic [31:0] pc);
    return {pc, pc | 32'hD000_0000, pc[6:2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    req_n = 0;
  endtask

  task automatic retire(input logic [31:0] pc);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_data  = pc | 32'hD000_0000;
    wb_rd    = pc[6:2];
  endtask

  task automatic exp_rd(input int dut, input string n, input int idx, input logic [EW-1:0] ent);
    exp_t x;
    x.dut = dut; x.ce = 1'b1; x.ent = ent; x.cs = 1'b0;
    x.cnt = 5'd0; x.tidx = 4'd0; x.trg = 1'b0; x.dn = 1'b0; x.to = 1'b0;
    if (dut == 0) rd_idx0 = 4'(idx);
    else          rd_idx1 = 4'(idx);
    exp_q.push_back(x);
    name_q.push_back(n);
    req_n++;
  endtask

  task automatic exp_st(input int dut, input string n, input int cnt, input int tidx,
                        input logic trg, input logic dn, input logic to);
    exp_t x;
    x.dut = dut; x.ce = 1'b0; x.ent = {EW{1'b0}}; x.cs = 1'b1;
    x.cnt = 5'(cnt); x.tidx = 4'(tidx); x.trg = trg; x.dn = dn; x.to = to;
    exp_q.push_back(x);
    name_q.push_back(n);
    req_n++;
  endtask

  task automatic cmp(input string n, input string fld, input logic [EW-1:0] got,
                     input logic [EW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s.%s: got %h required %h", n, fld, got, want);
    end
  endtask

  always @(posedge clk) vld_n <= req_n;

  // Monitor: each edge that had expectations queued is checked on the following negedge.
  always @(negedge clk) begin
    for (int i = 0; i < vld_n; i++) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL monitor: output presented with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.dut == 0) begin
          if (e.ce) cmp(nm, "rd_entry", if0.rd_entry, e.ent);
          if (e.cs) begin
            cmp(nm, "count",     EW'(if0.count),     EW'(e.cnt));
            cmp(nm, "trig_idx",  EW'(if0.trig_idx),  EW'(e.tidx));
            cmp(nm, "triggered", EW'(if0.triggered), EW'(e.trg));
            cmp(nm, "done",      EW'(if0.done),      EW'(e.dn));
            cmp(nm, "timeout",   EW'(if0.timeout),   EW'(e.to));
          end
        end else begin
          if (e.ce) cmp(nm, "rd_entry", if1.rd_entry, e.ent);
          if (e.cs) begin
            cmp(nm, "count",     EW'(if1.count),     EW'(e.cnt));
            cmp(nm, "trig_idx",  EW'(if1.trig_idx),  EW'(e.tidx));
            cmp(nm, "triggered", EW'(if1.triggered), EW'(e.trg));
            cmp(nm, "done",      EW'(if1.done),      EW'(e.dn));
            cmp(nm, "timeout",   EW'(if1.timeout),   EW'(e.to));
          end
        end
      end
    end
  end

  logic [31:0] bub_pc [6];
  logic        bub_v  [6];

  initial begin
    n_vec = 0; n_err = 0; req_n = 0;
    reset = 1'b1; arm = 1'b0; wb_valid = 1'b0; wb_pc = 32'h0; wb_data = 32'h0; wb_rd = 5'd0;
    trig_pc = 32'hFFFF_FFF0; post_len = 5'd0; cyc_limit = 32'd0; rd_idx0 = 4'd0; rd_idx1 = 4'd0;
    bub_v[0] = 1'b1; bub_v[1] = 1'b0; bub_v[2] = 1'b0; bub_v[3] = 1'b1; bub_v[4] = 1'b0; bub_v[5] = 1'b1;
    bub_pc[0] = 32'h100; bub_pc[1] = 32'h0; bub_pc[2] = 32'h0;
    bub_pc[3] = 32'h200; bub_pc[4] = 32'h0; bub_pc[5] = 32'h300;
    tick();
    tick();

    // Reset with retires toggling: everything reads as zero.
    for (int i = 0; i < 16; i++) begin
      retire(32'h0000_0100 + 32'(4 * i));
      wb_valid = i[0];
      exp_rd(0, "reset_rd", i, {EW{1'b0}});
      exp_st(1, "reset_st", 0, 0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      retire(32'h0000_0200 + 32'(4 * i));
      wb_valid = i[0];
      exp_rd(1, "idle_rd", i, {EW{1'b0}});
      exp_st(0, "idle_st", 0, 0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    wb_valid = 1'b0;

    // Wrap mode: trigger at 0x40, three post entries, stops after 0x4C.
    trig_pc = 32'h40; post_len = 5'd3; arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 20; k++) begin
      retire(32'(4 * k));
      if (k == 16) exp_st(0, "wrap_trig", 16, 15, 1'b1, 1'b0, 1'b0);
      if (k == 18) exp_st(0, "wrap_pre_done", 16, 13, 1'b1, 1'b0, 1'b0);
      if (k == 19) exp_st(0, "wrap_done", 16, 12, 1'b1, 1'b1, 1'b0);
      tick();
    end
    retire(32'h50);
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_rd(0, "wrap_rd", i, mk_entry(32'h10 + 32'(4 * i)));
      tick();
    end
    exp_st(0, "wrap_hold", 16, 12, 1'b1, 1'b1, 1'b0);
    tick();

    // Stop-full: no trigger, 20 retires, the stop-mode instance freezes after 16.
    trig_pc = 32'hFFFF_FFF0; arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 20; k++) begin
      retire(32'(4 * k));
      if (k == 14) exp_st(1, "full_pre", 15, 0, 1'b0, 1'b0, 1'b0);
      if (k == 15) exp_st(1, "full_done", 16, 0, 1'b0, 1'b1, 1'b0);
      if (k == 16) exp_rd(0, "collide_old", 0, mk_entry(32'h00));
      if (k == 19) exp_st(1, "full_hold", 16, 0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    wb_valid = 1'b0;
    exp_rd(1, "full_rd0", 0, mk_entry(32'h00));
    exp_rd(0, "free_rd0", 0, mk_entry(32'h10));
    tick();
    exp_rd(1, "full_rd15", 15, mk_entry(32'h3C));
    exp_rd(0, "free_rd15", 15, mk_entry(32'h4C));
    tick();
    exp_rd(1, "full_rd7", 7, mk_entry(32'h1C));
    tick();

    // Bubbles, with a retire on the arm cycle that must be dropped.
    arm = 1'b1;
    retire(32'h990);
    exp_st(0, "arm_drop", 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    arm = 1'b0;
    for (int i = 0; i < 6; i++) begin
      retire(bub_pc[i]);
      wb_valid = bub_v[i];
      tick();
    end
    wb_valid = 1'b0;
    exp_st(0, "bub_st0", 3, 0, 1'b0, 1'b0, 1'b0);
    exp_st(1, "bub_st1", 3, 0, 1'b0, 1'b0, 1'b0);
    exp_rd(0, "bub_a", 0, mk_entry(32'h100));
    exp_rd(1, "bub_b1", 1, mk_entry(32'h200));
    tick();
    exp_rd(0, "bub_b", 1, mk_entry(32'h200));
    tick();
    exp_rd(0, "bub_c", 2, mk_entry(32'h300));
    tick();
    exp_rd(0, "bub_past_end", 3, {EW{1'b0}});
    tick();

    // Timeout exactly 100 cycles after the arm edge.
    cyc_limit = 32'd100; arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (98) tick();
    exp_st(0, "tmo_99", 0, 0, 1'b0, 1'b0, 1'b0);
    exp_st(1, "tmo_99", 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    exp_st(0, "tmo_100", 0, 0, 1'b0, 1'b1, 1'b1);
    exp_st(1, "tmo_100", 0, 0, 1'b0, 1'b1, 1'b1);
    tick();
    cyc_limit = 32'd0;

    // Re-arm while in POST with seven entries stored.
    trig_pc = 32'h08; post_len = 5'd8; arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 7; k++) begin
      retire(32'(4 * k));
      if (k == 6) exp_st(0, "rearm_post", 7, 2, 1'b1, 1'b0, 1'b0);
      tick();
    end
    wb_valid = 1'b0;
    arm = 1'b1;
    exp_st(0, "rearm_clr", 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    arm = 1'b0;
    exp_rd(0, "rearm_rd0", 0, {EW{1'b0}});
    tick();
    retire(32'h80);
    exp_st(0, "rearm_cap", 1, 0, 1'b0, 1'b0, 1'b0);
    tick();
    wb_valid = 1'b0;
    exp_rd(0, "rearm_rd1", 0, mk_entry(32'h80));
    tick();

    // post_len of zero: the trigger capture itself completes the trace.
    trig_pc = 32'h80; post_len = 5'd0; arm = 1'b1;
    tick();
    arm = 1'b0;
    retire(32'h7C);
    tick();
    retire(32'h80);
    exp_st(0, "post0_done", 2, 1, 1'b1, 1'b1, 1'b0);
    tick();
    retire(32'h84);
    exp_st(1, "post0_hold", 2, 1, 1'b1, 1'b1, 1'b0);
    tick();
    wb_valid = 1'b0;

    tick();
    tick();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations never checked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
